// File: rtl/cpu_state_dumper.sv
// End-of-run observer: after TRIGGER_CYCLE enabled cycles (or a force request) it streams
// r0..r(NUM_REGS-1) then m0..m(NUM_MEM-1) out on a valid/ready port, freezing the CPU meanwhile.
module cpu_state_dumper #(
    parameter int TRIGGER_CYCLE = 30,
    parameter int NUM_REGS      = 32,
    parameter int NUM_MEM       = 32,
    parameter int DATA_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              force_i,
    output logic [4:0]        rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [31:0]       dm_addr_o,
    input  logic [DATA_W-1:0] dm_data_i,
    output logic              freeze_o,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic              dump_sel_o,
    output logic [5:0]        dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = (TRIGGER_CYCLE < 1) ? 1 : $clog2(TRIGGER_CYCLE + 1);

    typedef enum logic [1:0] {S_IDLE, S_REG, S_MEM, S_DONE} state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [5:0]          rd_idx_q;
    logic                freeze_q, valid_q, sel_q, last_q, busy_q, done_q;
    logic [5:0]          idx_q;
    logic [DATA_W-1:0]   data_q;

    logic                load_d;
    logic                trigger_d;
    logic [DATA_W-1:0]   rd_data_d;

    // The output register refills whenever it is empty or being drained this cycle.
    always_comb begin
        load_d    = 1'b0;
        trigger_d = 1'b0;
        rd_data_d = rf_data_i;
        load_d    = (state_q == S_REG || state_q == S_MEM) && (!valid_q || dump_ready_i);
        trigger_d = force_i || (en_i && cnt_q == CNT_W'(TRIGGER_CYCLE - 1));
        if (state_q == S_MEM) rd_data_d = dm_data_i;
    end

    assign rf_addr_o = (state_q == S_REG) ? rd_idx_q[4:0] : 5'd0;
    assign dm_addr_o = (state_q == S_MEM) ? {24'd0, rd_idx_q, 2'b00} : 32'd0;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rd_idx_q <= '0;
            freeze_q <= 1'b0;
            valid_q  <= 1'b0;
            sel_q    <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
            data_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger_d) begin
                        state_q  <= S_REG;
                        freeze_q <= 1'b1;
                        busy_q   <= 1'b1;
                        rd_idx_q <= '0;
                    end else if (en_i && cnt_q != CNT_W'(TRIGGER_CYCLE)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_REG, S_MEM: begin
                    if (load_d) begin
                        valid_q  <= 1'b1;
                        data_q   <= rd_data_d;
                        sel_q    <= (state_q == S_MEM);
                        idx_q    <= rd_idx_q;
                        last_q   <= (state_q == S_MEM) && (rd_idx_q == 6'(NUM_MEM - 1));
                        rd_idx_q <= rd_idx_q + 6'd1;
                        if (state_q == S_REG && rd_idx_q == 6'(NUM_REGS - 1)) begin
                            state_q  <= S_MEM;
                            rd_idx_q <= '0;
                        end else if (state_q == S_MEM && rd_idx_q == 6'(NUM_MEM - 1)) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            rd_idx_q <= '0;
                        end
                    end
                end
                S_DONE: begin
                    // Last word drains here; the CPU is released in the same edge done rises.
                    if (!valid_q || dump_ready_i) begin
                        valid_q  <= 1'b0;
                        done_q   <= 1'b1;
                        freeze_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign freeze_o     = freeze_q;
    assign dump_valid_o = valid_q;
    assign dump_sel_o   = sel_q;
    assign dump_idx_o   = idx_q;
    assign dump_data_o  = data_q;
    assign dump_last_o  = last_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
